// File: rtl/tt_um_cla_seq16.sv
// Sequential 16-bit adder: accepts four nibble pairs (LSB first) over a
// valid/ready handshake, chains the carry through a 4-bit carry-lookahead
// stage, then returns the sum as two bytes plus carry-out and signed overflow.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid come only from the state register, so
// neither depends combinationally on in_valid or out_ready. The producer may
// hold or drop valid freely, and nothing is consumed unless ready is high.
module tt_um_cla_seq16 (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'b00,
    ST_OUT_LO = 2'b01,
    ST_OUT_HI = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  beat_q;
  logic [15:0] result_q;
  logic        carry_q;
  logic        ovf_q;

  logic        in_valid, cin_init, clear, out_ready;
  logic        in_ready, out_valid;
  logic        accept, beat_zero;
  logic [3:0]  a_nib, b_nib, p, g, cc, sum;
  logic        c_in;
  logic        unused_ok;

  assign in_valid  = uio_in[0];
  assign cin_init  = uio_in[1];
  assign clear     = uio_in[2];
  assign out_ready = uio_in[3];
  assign unused_ok = &{1'b0, ena, uio_in[7:4]};

  assign a_nib = ui_in[3:0];
  assign b_nib = ui_in[7:4];

  // Carry-lookahead nibble adder; beat 0 takes cin_init, later beats the chained carry
  always_comb begin
    c_in  = (beat_q == 2'd0) ? cin_init : carry_q;
    p     = a_nib ^ b_nib;
    g     = a_nib & b_nib;
    cc[0] = g[0] | (p[0] & c_in);
    cc[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    cc[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    cc[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c_in);
    sum   = p ^ {cc[2:0], c_in};
  end

  // Next-state and Moore output decode; the unused encoding falls back to LOAD
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    beat_zero = 1'b0;
    uo_out    = 8'h00;
    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (beat_q == 2'd3) state_d = ST_OUT_LO;
        end
      end
      ST_OUT_LO: begin
        out_valid = 1'b1;
        uo_out    = result_q[7:0];
        if (out_ready) state_d = ST_OUT_HI;
      end
      ST_OUT_HI: begin
        out_valid = 1'b1;
        uo_out    = result_q[15:8];
        if (out_ready) begin
          state_d   = ST_LOAD;
          beat_zero = 1'b1;
        end
      end
      default: begin
        state_d   = ST_LOAD;
        beat_zero = 1'b1;
      end
    endcase
  end

  assign uio_out = {out_valid & ovf_q, out_valid & carry_q, out_valid, in_ready, 4'b0000};
  assign uio_oe  = 8'hF0;

  // State register and datapath; clear wins over any handshake in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      beat_q   <= 2'd0;
      result_q <= 16'h0000;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (clear) begin
      state_q  <= ST_LOAD;
      beat_q   <= 2'd0;
      result_q <= 16'h0000;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        result_q[{beat_q, 2'b00} +: 4] <= sum;
        carry_q <= cc[3];
        beat_q  <= beat_q + 2'd1;
        // Signed overflow: carry into bit 15 differs from carry out of bit 15
        if (beat_q == 2'd3) ovf_q <= cc[2] ^ cc[3];
      end else if (beat_zero) begin
        beat_q <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_tt_um_cla_seq16.sv
// Bench for tt_um_cla_seq16: directed corner cases plus randomized operations
// checked against an arithmetic model of 16-bit addition.
module tb_tt_um_cla_seq16;

  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  logic       ena, clk, rst_n;

  int n_cmp = 0;
  int n_err = 0;

  // {ovf, cout, hi byte, lo byte}
  logic [17:0] exp_q[$];

  tt_um_cla_seq16 dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 17-bit addition, two's-complement overflow rule
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    logic [16:0] s;
    logic        v;
    s = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
    v = (a[15] == b[15]) && (s[15] != a[15]);
    return {v, s[16], s[15:0]};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_out"}, {8'h00, uo_out}, 16'h0000);
    check({tag, "_uio"}, {8'h00, uio_out}, 16'h0010);
    check({tag, "_oe"},  {8'h00, uio_oe},  16'h00F0);
  endtask

  // Driver: present the first n beats; optional idle gap before beat 2
  task automatic drive_beats(input logic [15:0] a, input logic [15:0] b, input logic cin,
                             input bit rnd_later, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      if (k == 2 && gap > 0) begin
        uio_in[0] = 1'b0;
        repeat (gap) begin
          tick();
          check("gap_in_ready", {15'd0, uio_out[4]}, 16'd1);
          check("gap_out_valid", {15'd0, uio_out[5]}, 16'd0);
        end
      end
      ui_in     = {b[4*k +: 4], a[4*k +: 4]};
      uio_in[0] = 1'b1;
      uio_in[1] = (k == 0) ? cin : (rnd_later ? 1'($urandom_range(0, 1)) : 1'b0);
      check("beat_in_ready", {15'd0, uio_out[4]}, 16'd1);
      tick();
    end
    uio_in[0] = 1'b0;
    uio_in[1] = 1'b0;
  endtask

  task automatic send_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input bit rnd_later, input int gap);
    exp_q.push_back(model(a, b, cin));
    drive_beats(a, b, cin, rnd_later, 4, gap);
  endtask

  // Sink: hold out_ready low for 'hold' cycles while poking in_valid, then drain
  task automatic recv_op(input int hold);
    logic [17:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 16'd1, 16'd0);
      return;
    end
    e = exp_q.pop_front();
    check("lo_valid", {15'd0, uio_out[5]}, 16'd1);
    check("lo_in_ready", {15'd0, uio_out[4]}, 16'd0);
    check("lo_byte", {8'h00, uo_out}, {8'h00, e[7:0]});
    check("lo_cout_ovf", {14'd0, uio_out[7:6]}, {14'd0, e[17:16]});
    uio_in[3] = 1'b0;
    for (int i = 0; i < hold; i++) begin
      uio_in[0] = 1'($urandom_range(0, 1));
      ui_in     = 8'($urandom);
      tick();
      check("hold_byte", {8'h00, uo_out}, {8'h00, e[7:0]});
      check("hold_flags", {12'd0, uio_out[7:4]}, {12'd0, e[17:16], 2'b10});
    end
    uio_in[0] = 1'b0;
    uio_in[3] = 1'b1;
    tick();
    check("hi_valid", {15'd0, uio_out[5]}, 16'd1);
    check("hi_byte", {8'h00, uo_out}, {8'h00, e[15:8]});
    check("hi_cout_ovf", {14'd0, uio_out[7:6]}, {14'd0, e[17:16]});
    tick();
    uio_in[3] = 1'b0;
    check_idle("post_op");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    ui_in  = 8'h00;
    uio_in = 8'h00;
    ena    = 1'b1;
    rst_n  = 1'b0;
    repeat (2) tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();
    check_idle("after_reset");

    // Directed arithmetic corners
    send_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0); recv_op(0);
    send_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0); recv_op(0);
    send_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0); recv_op(0);
    send_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0); recv_op(0);
    send_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0); recv_op(0);

    // Backpressure and input gap
    send_op(16'hA5C3, 16'h3C5A, 1'b1, 1'b1, 3); recv_op(5);

    // Reset after two beats, then a fresh operation
    drive_beats(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 2, 0);
    do_reset();
    send_op(16'h0101, 16'h0202, 1'b0, 1'b0, 0); recv_op(0);

    // Reset while the result is being presented
    send_op(16'h1111, 16'h2222, 1'b0, 1'b0, 0);
    check("pre_rst_valid", {15'd0, uio_out[5]}, 16'd1);
    void'(exp_q.pop_back());
    do_reset();

    // Clear in the same cycle as beat 3
    drive_beats(16'hFFFF, 16'h0001, 1'b1, 1'b0, 3, 0);
    ui_in     = 8'h10;
    uio_in[0] = 1'b1;
    uio_in[2] = 1'b1;
    tick();
    uio_in[0] = 1'b0;
    uio_in[2] = 1'b0;
    check_idle("clear_beat3");
    tick();
    check_idle("clear_hold");
    send_op(16'h0000, 16'h0000, 1'b0, 1'b0, 0); recv_op(0);
    send_op(16'h00F0, 16'h0010, 1'b0, 1'b0, 0); recv_op(0);

    // Randomized operations
    for (int n = 0; n < 30; n++) begin
      send_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      recv_op(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    check("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
